// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage sequencer.
//   pc_seq_state_e : sequencer FSM state encoding
//   INSN_BYTES     : bytes per instruction (sequential PC increment)
//   align_pc       : clears the two low address bits of a target
package pc_seq_pkg;

    typedef enum logic [1:0] {
        PS_FETCH = 2'd0,
        PS_DRAIN = 2'd1,
        PS_HOLD  = 2'd2
    } pc_seq_state_e;

    localparam int unsigned INSN_BYTES = 4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch sequencer.
// Priority is trap > redirect > sequential. Redirect targets are word aligned.
// Optional feature macro: PC_TRAP_EN (adds the trap inputs).
// Ports:
//   trap_valid_i     in  1   trap request (PC_TRAP_EN only)
//   trap_pc_i        in  32  trap target (PC_TRAP_EN only)
//   redirect_valid_i in  1   branch/jump taken
//   redirect_pc_i    in  32  branch/jump target, low two bits ignored
//   pc_i             in  32  current fetch PC
//   redir_o          out 1   any redirect (trap or branch) this cycle
//   target_o         out 32  selected redirect target
//   next_pc_o        out 32  target on redirect, else pc_i + INSN_BYTES
module pc_next_sel
    import pc_seq_pkg::*;
(
`ifdef PC_TRAP_EN
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
`endif
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] pc_i,
    output logic        redir_o,
    output logic [31:0] target_o,
    output logic [31:0] next_pc_o
);

    always_comb begin
        redir_o  = redirect_valid_i;
        target_o = align_pc(redirect_pc_i);
`ifdef PC_TRAP_EN
        if (trap_valid_i) begin
            redir_o  = 1'b1;
            target_o = align_pc(trap_pc_i);
        end
`endif
        // 32-bit add wraps naturally from 32'hFFFF_FFFC to 0
        next_pc_o = redir_o ? target_o : (pc_i + 32'(INSN_BYTES));
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller. Owns the PC, issues one imem
// request/ack transaction per instruction, applies redirects (flushing stale
// fetches) and hands instructions to decode through a 1-entry skid buffer.
// Optional feature macro: PC_TRAP_EN (trap_valid port, redirect to TRAP_VECTOR).
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   redirect_valid  in   branch/jump taken;  redirect_pc in  target
//   imem_req/addr   out  fetch request and address (stable until ack)
//   imem_ack/rdata  in   fetch completion and instruction
//   if_valid/pc/instr out  instruction presented to decode; if_ready in
//   pc_out          out  next fetch address
//   trap_valid      in   trap request (PC_TRAP_EN only)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PS_FETCH | request at pc outstanding (or being issued), waiting for ack
// PS_DRAIN | redirected while a request was in flight; discard its data
// PS_HOLD  | output and skid both full; no request until decode drains
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc_out
`ifdef PC_TRAP_EN
    ,
    input  logic        trap_valid
`endif
);

    pc_seq_state_e state_q;
    logic [31:0]   pc_q;
    logic          imem_req_q;
    logic [31:0]   imem_addr_q;
    logic          if_valid_q;
    logic [31:0]   if_pc_q;
    logic [31:0]   if_instr_q;
    logic [31:0]   skid_pc_q;
    logic [31:0]   skid_instr_q;

    logic          redir;
    logic [31:0]   redir_target;
    logic [31:0]   pc_d;

    pc_next_sel u_next_sel (
`ifdef PC_TRAP_EN
        .trap_valid_i     (trap_valid),
        .trap_pc_i        (TRAP_VECTOR),
`endif
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_i             (pc_q),
        .redir_o          (redir),
        .target_o         (redir_target),
        .next_pc_o        (pc_d)
    );

    // In DRAIN, pc_q already holds the pending redirect target while
    // imem_addr_q keeps the address of the transaction being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PS_FETCH;
            pc_q         <= RESET_VECTOR;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= 32'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
        end else begin
            case (state_q)
                PS_FETCH: begin
                    if (redir) begin
                        if_valid_q <= 1'b0;
                        pc_q       <= redir_target;
                        if (imem_req_q && !imem_ack) begin
                            state_q <= PS_DRAIN;
                        end else begin
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= redir_target;
                        end
                    end else if (imem_req_q && imem_ack) begin
                        pc_q        <= pc_d;
                        imem_addr_q <= pc_d;
                        if (!if_valid_q || if_ready) begin
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q;
                            if_instr_q <= imem_rdata;
                        end else begin
                            skid_pc_q    <= pc_q;
                            skid_instr_q <= imem_rdata;
                            imem_req_q   <= 1'b0;
                            state_q      <= PS_HOLD;
                        end
                    end else begin
                        if (if_ready) begin
                            if_valid_q <= 1'b0;
                        end
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end
                PS_DRAIN: begin
                    if_valid_q <= 1'b0;
                    if (redir) begin
                        pc_q <= redir_target;
                    end
                    if (imem_ack) begin
                        state_q     <= PS_FETCH;
                        imem_addr_q <= redir ? redir_target : pc_q;
                    end
                end
                PS_HOLD: begin
                    if (redir) begin
                        if_valid_q  <= 1'b0;
                        pc_q        <= redir_target;
                        state_q     <= PS_FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= redir_target;
                    end else if (if_ready) begin
                        if_pc_q     <= skid_pc_q;
                        if_instr_q  <= skid_instr_q;
                        state_q     <= PS_FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end
                default: begin
                    state_q <= PS_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign pc_out    = pc_q;

endmodule
